// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared constants, fetch-state encoding and PC helper for
//                the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_FETCH   = 2'd0,
        IF_HOLD    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    // Sequential successor; 32-bit modulo so the top word wraps to zero.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Clear inserts a bubble (valid and
//                instruction reset, PC fields kept), load captures a new
//                instruction, otherwise every field holds.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus8
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus8;

    // Register update: reset, then bubble, then load, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_pc       <= 32'h0000_0000;
            r_pc_plus8 <= 32'h0000_0008;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_inst     <= i_inst;
            r_pc       <= i_pc;
            r_pc_plus8 <= i_pc + 32'd8;
        end
    end

    assign o_valid    = r_valid;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_pc_plus8 = r_pc_plus8;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the PC, next-PC selection
//                with a one-slot branch delay, the instruction-memory
//                request/ready handshake, stall buffering and exception
//                flush, and feeds the IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rdy,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus8
);

    if_state_e   r_state;
    if_state_e   w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_disc_addr;     // address of the stale request being drained
    logic [31:0] r_buf_inst;      // word fetched while ID was stalled
    logic [31:0] r_buf_pc;
    logic        r_pend_valid;    // redirect waiting for its delay slot
    logic [31:0] r_pend_target;

    logic        w_accept;
    logic        w_redir;
    logic        w_fetch_done;
    logic        w_to_hold;
    logic        w_commit;
    logic        w_clear;
    logic [31:0] w_load_inst;
    logic [31:0] w_load_pc;
    logic [31:0] w_npc;

    // IF/ID can take a word if ID is moving or currently empty.
    assign w_accept     = !stall_id || !id_valid;
    // Redirects only count when ID actually advances the branch.
    assign w_redir      = redirect_valid && !stall_id;
    assign w_fetch_done = (r_state == IF_FETCH) && inst_rdy;
    assign w_to_hold    = w_fetch_done && !w_accept && !flush;

    // A commit moves either the live response or the buffered word into IF/ID.
    assign w_commit = !flush &&
                      ((w_fetch_done && w_accept) ||
                       ((r_state == IF_HOLD) && !stall_id));

    assign w_load_inst = (r_state == IF_HOLD) ? r_buf_inst : inst_rdata;
    assign w_load_pc   = (r_state == IF_HOLD) ? r_buf_pc   : r_pc;

    // The committing instruction is the delay slot when a redirect is seen
    // this cycle or one is already pending.
    assign w_npc = w_redir      ? redirect_target :
                   r_pend_valid ? r_pend_target   :
                                  pc_plus4(w_load_pc);

    // Bubble on flush, or whenever ID advances with nothing new to give it.
    assign w_clear = flush || (!stall_id && !w_commit);

    // Fetch-state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IF_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory-request outputs.
    always_comb begin
        w_state_nxt = r_state;
        inst_req    = 1'b0;
        inst_addr   = r_pc;
        case (r_state)
            IF_FETCH: begin
                inst_req = !rst;
                if (flush) begin
                    w_state_nxt = inst_rdy ? IF_FETCH : IF_DISCARD;
                end else if (inst_rdy && !w_accept) begin
                    w_state_nxt = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (flush || !stall_id) begin
                    w_state_nxt = IF_FETCH;
                end
            end
            IF_DISCARD: begin
                inst_req  = !rst;
                inst_addr = r_disc_addr;
                if (inst_rdy) begin
                    w_state_nxt = IF_FETCH;
                end
            end
            default: begin
                w_state_nxt = IF_FETCH;
            end
        endcase
    end

    // Program counter: flush target beats the normal next-PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (flush) begin
            r_pc <= flush_pc;
        end else if (w_commit) begin
            r_pc <= w_npc;
        end
    end

    // Pending redirect: armed when the delay slot has not yet committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
        end else if (flush) begin
            r_pend_valid  <= 1'b0;
        end else if (w_redir && !w_commit) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= redirect_target;
        end else if (w_commit) begin
            r_pend_valid  <= 1'b0;
        end
    end

    // Stall buffer and stale-request address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_inst  <= NOP_INST;
            r_buf_pc    <= RESET_PC;
            r_disc_addr <= RESET_PC;
        end else begin
            if (w_to_hold) begin
                r_buf_inst <= inst_rdata;
                r_buf_pc   <= r_pc;
            end
            if ((r_state == IF_FETCH) && flush && !inst_rdy) begin
                r_disc_addr <= r_pc;
            end
        end
    end

    if_id_reg #(
        .NOP_INST   (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_commit),
        .i_clear    (w_clear),
        .i_inst     (w_load_inst),
        .i_pc       (w_load_pc),
        .o_valid    (id_valid),
        .o_inst     (id_inst),
        .o_pc       (id_pc),
        .o_pc_plus8 (id_pc_plus8)
    );

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for if_stage with a scoreboard
//                of instructions expected to enter IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_rdy;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_err    = 0;

    // Memory contents: a word that encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0000};
    endfunction

    assign inst_rdata = mem_word(inst_addr);

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_rdata      (inst_rdata),
        .inst_rdy        (inst_rdy),
        .stall_id        (stall_id),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_pc_plus8     (id_pc_plus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        sb_entry_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb_q.push_back(e);
    endtask

    // One clock; afterwards, any newly loaded IF/ID entry is popped and compared.
    task automatic tick();
        logic      ps;
        logic      pv;
        sb_entry_t e;
        ps = stall_id;
        pv = id_valid;
        @(posedge clk);
        #1;
        if (id_valid === 1'b1 && !(ps && pv)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_load", id_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_id_pc",     id_pc,       e.pc);
                chk("sb_id_inst",   id_inst,     e.inst);
                chk("sb_id_pc_p8",  id_pc_plus8, e.pc + 32'd8);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        inst_rdy        = 1'b0;
        stall_id        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        flush           = 1'b0;
        flush_pc        = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_inst_req",  {31'd0, inst_req}, 32'd0);
        chk("rst_id_valid",  {31'd0, id_valid}, 32'd0);
        chk("rst_id_inst",   id_inst,     32'h0);
        chk("rst_id_pc",     id_pc,       32'h0);
        chk("rst_id_pc_p8",  id_pc_plus8, 32'h8);
        rst = 1'b0;
        #1;
        chk("post_rst_req",  {31'd0, inst_req}, 32'd1);
        chk("post_rst_addr", inst_addr, 32'h0);

        // Zero-wait memory: one instruction per cycle
        inst_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("zw_addr", inst_addr, 32'(4 * k));
            push(32'(4 * k));
            tick();
        end

        // Three-cycle memory latency at 0x10
        inst_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_addr",   inst_addr, 32'h10);
            chk("wait_req",    {31'd0, inst_req}, 32'd1);
            chk("wait_bubble", {31'd0, id_valid}, 32'd0);
        end
        inst_rdy = 1'b1;
        push(32'h10);
        tick();

        // Stall while the fetch of 0x14 completes
        stall_id = 1'b1;
        tick();
        chk("hold_req",   {31'd0, inst_req}, 32'd0);
        chk("hold_id_pc", id_pc, 32'h10);
        tick();
        chk("hold2_req",   {31'd0, inst_req}, 32'd0);
        chk("hold2_id_pc", id_pc, 32'h10);
        chk("hold2_valid", {31'd0, id_valid}, 32'd1);
        stall_id = 1'b0;
        push(32'h14);
        tick();
        chk("unhold_req",  {31'd0, inst_req}, 32'd1);
        chk("unhold_addr", inst_addr, 32'h18);

        // Redirect with the delay slot committing in the same cycle
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        push(32'h18);
        tick();
        redirect_valid  = 1'b0;
        chk("redir_addr", inst_addr, 32'h40);
        push(32'h40);
        tick();
        chk("redir_next", inst_addr, 32'h44);

        // Redirect while memory is busy: target must be held pending
        inst_rdy        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid  = 1'b0;
        chk("pend_bubble", {31'd0, id_valid}, 32'd0);
        chk("pend_addr",   inst_addr, 32'h44);
        inst_rdy = 1'b1;
        push(32'h44);
        tick();
        chk("pend_target", inst_addr, 32'h100);

        // Flush while the request at 0x100 is outstanding
        inst_rdy = 1'b0;
        tick();
        flush    = 1'b1;
        flush_pc = 32'h380;
        tick();
        flush    = 1'b0;
        chk("disc_valid", {31'd0, id_valid}, 32'd0);
        chk("disc_req",   {31'd0, inst_req}, 32'd1);
        chk("disc_addr",  inst_addr, 32'h100);
        tick();
        chk("disc_addr2", inst_addr, 32'h100);
        inst_rdy = 1'b1;
        tick();
        chk("disc_drop",  {31'd0, id_valid}, 32'd0);
        chk("flush_addr", inst_addr, 32'h380);
        push(32'h380);
        tick();
        chk("flush_next", inst_addr, 32'h384);

        // Flush and redirect together: flush wins, pending cleared
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        flush           = 1'b1;
        flush_pc        = 32'h500;
        tick();
        redirect_valid  = 1'b0;
        flush           = 1'b0;
        chk("fr_bubble", {31'd0, id_valid}, 32'd0);
        chk("fr_addr",   inst_addr, 32'h500);
        push(32'h500);
        tick();
        chk("fr_seq1", inst_addr, 32'h504);
        push(32'h504);
        tick();
        chk("fr_seq2", inst_addr, 32'h508);

        // PC wrap at the top of the address space
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush    = 1'b0;
        chk("wrap_start", inst_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", inst_addr, 32'h0);
        push(32'h0);
        tick();

        // Reset with a request outstanding
        inst_rdy = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst2_req",    {31'd0, inst_req}, 32'd0);
        chk("rst2_valid",  {31'd0, id_valid}, 32'd0);
        chk("rst2_id_pc",  id_pc,       32'h0);
        chk("rst2_id_p8",  id_pc_plus8, 32'h8);
        rst = 1'b0;
        #1;
        chk("rst2_addr",   inst_addr, 32'h0);
        chk("rst2_req_up", {31'd0, inst_req}, 32'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC and the next-PC selection, and drives the instruction-memory request/ready handshake.
- Holds the IF/ID pipeline register whose id_inst[31:26] feeds the main decoder's op input.
- Supports multi-cycle instruction memory, ID stall, branch/jump redirect with one delay slot, and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID for bubbles and flushes.

Ports:
- clk  in  1  clock (rising edge).
- rst  in  1  synchronous, active-high reset.
- inst_req  out  1  fetch request to instruction memory.
- inst_addr  out  32  fetch address; stable while inst_req=1 until inst_rdy.
- inst_rdata  in  32  fetched word, valid when inst_rdy=1.
- inst_rdy  in  1  memory completes the current request this cycle.
- stall_id  in  1  ID cannot accept a new instruction; IF/ID must hold.
- redirect_valid  in  1  one-cycle pulse from ID (branch taken, j, jal, jr); sampled only when stall_id=0.
- redirect_target  in  32  target PC accompanying redirect_valid.
- flush  in  1  exception flush; highest priority.
- flush_pc  in  32  handler PC applied on flush.
- id_valid  out  1  IF/ID holds a real instruction.
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  PC of id_inst.
- id_pc_plus8  out  32  id_pc+8, the jal/jalr link value.

Behaviour:
- Reset: pc=RESET_PC; state=FETCH; id_valid=0; id_inst=NOP_INST; id_pc=0; id_pc_plus8=8; redirect pending cleared.
- inst_req is 0 in the reset cycle and rises the cycle after rst deasserts.
- States:
  - FETCH: inst_req=1, inst_addr=pc.
  - HOLD: inst_req=0; fetched word is buffered because ID is stalled.
  - DISCARD: inst_req=1, inst_addr=the old address; waiting to drop a stale response.
- accept = !stall_id || !id_valid.
- FETCH, inst_rdy=1, accept=1:
  - IF/ID <= {1, inst_rdata, pc}.
  - pc <= npc.
  - Remain in FETCH; the new request is issued the next cycle.
  - A zero-wait memory therefore gives 1 instruction per cycle.
- FETCH, inst_rdy=1, accept=0: buffer {inst_rdata, pc} and go to HOLD; pc is unchanged.
- HOLD, stall_id=0: IF/ID <= buffer; pc <= npc; go to FETCH.
- No new instruction while stall_id=0: IF/ID <= bubble (id_valid=0, id_inst=NOP_INST, id_pc unchanged).
- stall_id=1: IF/ID holds every field.
- npc = pending_valid ? pending_target : pc+4. The addition is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0.
- Redirect (delay slot):
  - redirect_valid with stall_id=0 sets pending_valid=1 and pending_target=redirect_target.
  - The next instruction to commit into IF/ID (the delay slot) uses npc=pending_target, then clears pending.
  - If that delay-slot fetch commits in the same cycle as redirect_valid, npc=redirect_target directly and pending is not set.
  - redirect_valid while pending_valid=1 overwrites pending_target.
- Flush (overrides stall, redirect and inst_rdy):
  - IF/ID <= bubble; pending cleared; pc <= flush_pc; HOLD buffer dropped.
  - If in FETCH with inst_rdy=0, go to DISCARD.
  - Otherwise go to FETCH with the new pc.
- DISCARD: on inst_rdy the response is dropped and the state goes to FETCH. A flush during DISCARD only updates pc.
- Low PC bits pass through unchanged; alignment exceptions are detected downstream.
- rst in any state, including with a request outstanding, returns to reset values next cycle. The memory side is reset by the same rst.

Decomposition:
- Shared defines.vh: RESET_PC and NOP_INST values, plus 2-bit state encodings IF_FETCH=0, IF_HOLD=1, IF_DISCARD=2.
- One sub-module, if_id_reg: the 32+32+32+1-bit register with enable (load), clear (bubble) and hold.
- PC, FSM and pending-redirect logic live in if_stage.

Test Plan:
- Reset, then zero-wait memory (inst_rdy=1 always) -> inst_addr sequence 0,4,8,C; id_pc follows one cycle later; id_pc_plus8 = id_pc+8.
- inst_rdy delayed 3 cycles at addr 4 -> inst_addr stays 4 for all 3 cycles; id_valid=0 bubbles; then id_inst=word@4.
- stall_id=1 for 2 cycles while fetch of 8 completes -> HOLD entered, inst_req=0, IF/ID holds word@4; after release id_pc=8, then fetch C.
- Branch in ID at 0x10 with redirect_valid=1 and target 0x40 -> delay slot 0x14 enters IF/ID, next inst_addr=0x40, no 0x18 fetch.
- flush=1 (flush_pc=0x380) while fetch at 0x20 is outstanding -> id_valid=0, DISCARD holds addr 0x20 until inst_rdy, that word is dropped, next inst_addr=0x380.
- Flush and redirect_valid in the same cycle -> flush wins, pending cleared, next fetch at flush_pc.
